// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into instr[31:7] for the given ImmSrc type.
// Optional saturating error counter enabled by defining IMM_ENCODER_ERR_CNT_EN.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_imm,
  input  logic [2:0]           in_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [24:0]          out_enc,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  logic        s1_valid_q;
  logic [31:0] s1_imm_q;
  logic [2:0]  s1_src_q;
  logic        out_valid_q;
  logic [24:0] out_enc_q;
  logic        out_err_q;

  logic        s2_adv;
  logic        s1_adv;
  logic [24:0] enc_d;
  logic        err_d;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // A signed value fits in N bits when bits [31:N-1] are all copies of the sign.
  assign fits_12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
  assign fits_13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
  assign fits_21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

  // out_enc[k] holds instr[k+7].
  always_comb begin
    enc_d = '0;
    err_d = 1'b0;
    case (s1_src_q)
      SRC_I: begin
        enc_d[24:13] = s1_imm_q[11:0];
        err_d        = !fits_12;
      end
      SRC_S: begin
        enc_d[24:18] = s1_imm_q[11:5];
        enc_d[4:0]   = s1_imm_q[4:0];
        err_d        = !fits_12;
      end
      SRC_B: begin
        enc_d[24]    = s1_imm_q[12];
        enc_d[23:18] = s1_imm_q[10:5];
        enc_d[4:1]   = s1_imm_q[4:1];
        enc_d[0]     = s1_imm_q[11];
        err_d        = !fits_13 || s1_imm_q[0];
      end
      SRC_U: begin
        enc_d[24:5] = s1_imm_q[31:12];
        err_d       = |s1_imm_q[11:0];
      end
      SRC_J: begin
        enc_d[24]    = s1_imm_q[20];
        enc_d[23:14] = s1_imm_q[10:1];
        enc_d[13]    = s1_imm_q[11];
        enc_d[12:5]  = s1_imm_q[19:12];
        err_d        = !fits_21 || s1_imm_q[0];
      end
      default: begin
        enc_d = '0;
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_imm_q <= in_imm;
        s1_src_q <= in_src;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_enc_q   <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_enc_q <= enc_d;
        out_err_q <= err_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_enc   = out_enc_q;
  assign out_err   = out_err_q;

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (out_valid_q && out_ready && out_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes expected beats, a monitor pops and compares.
module tb_imm_encoder;

  localparam int unsigned ERR_CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_imm;
  logic [2:0]           in_src;
  logic                 out_valid;
  logic                 out_ready;
  logic [24:0]          out_enc;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_src    (in_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_enc   (out_enc),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [24:0] enc;
    logic        err;
  } beat_t;

  beat_t       sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned model_cnt = 0;
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: place immediate bits at instruction positions, range check in signed math.
  function automatic beat_t model(input logic [31:0] imm, input logic [2:0] src);
    beat_t       b;
    logic [31:0] instr;
    longint      v;
    v     = longint'($signed(imm));
    instr = '0;
    b.imm = imm;
    b.src = src;
    b.err = 1'b0;
    case (src)
      3'd0: begin
        instr[31:20] = imm[11:0];
        b.err = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        b.err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        b.err = (v < -4096) || (v > 4095) || (imm[0] == 1'b1);
      end
      3'd3: begin
        instr[31:12] = imm[31:12];
        b.err = (imm[11:0] != 12'd0);
      end
      3'd4: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        b.err = (v < -1048576) || (v > 1048575) || (imm[0] == 1'b1);
      end
      default: begin
        instr = '0;
        b.err = 1'b1;
      end
    endcase
    b.enc = instr[31:7];
    return b;
  endfunction

  // Core-side immediate extender, used for the round-trip check.
  function automatic logic [31:0] extend(input logic [24:0] enc, input logic [2:0] src);
    logic [31:0] i;
    i = {enc, 7'b0};
    case (src)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] src);
    int r;
    case (src)
      3'd0, 3'd1: r = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       r = (int'($urandom_range(0, 8191)) - 4096) & ~1;
      3'd3:       return $urandom & 32'hFFFF_F000;
      default:    r = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
    endcase
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] imm, input logic [2:0] src, input bit use_c,
                      input logic [24:0] c_enc, input logic c_err);
    beat_t b;
    int    t;
    b = model(imm, src);
    if (use_c) begin
      b.enc = c_enc;
      b.err = c_err;
    end
    in_imm   = imm;
    in_src   = src;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !reset) begin
        sb_q.push_back(b);
        break;
      end
      t++;
      if (t >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", t);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: stall stability plus in-order scoreboard compare on each output transfer.
  initial begin
    beat_t       b;
    logic        hold;
    logic [24:0] hold_enc;
    logic        hold_err;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold      = 1'b0;
        model_cnt = 0;
      end else begin
        if (hold) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_enc", out_enc, hold_enc);
          chk("stall_err", out_err, hold_err);
        end
        hold = 1'b0;
        if (out_valid && !out_ready) begin
          hold     = 1'b1;
          hold_enc = out_enc;
          hold_err = out_err;
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got enc 0x%0h with none pending, expected no beat",
                     out_enc);
          end else begin
            b = sb_q.pop_front();
            chk("enc", out_enc, b.enc);
            chk("err", out_err, b.err);
            if (!b.err) chk("roundtrip", extend(out_enc, b.src), b.imm);
`ifdef IMM_ENCODER_ERR_CNT_EN
            chk("err_count", err_count, model_cnt);
`else
            chk("err_count", err_count, 0);
`endif
            if (b.err && model_cnt < (1 << ERR_CNT_W) - 1) model_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] src;
    logic [31:0] imm;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_src    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_enc", out_enc, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);
    reset     = 1'b0;
    out_ready = 1'b1;

    // Latency and directed encodings
    send(32'hFFFF_FFFF, 3'd0, 1, 25'h1FFE000, 1'b0);
    chk("lat_after_accept", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_two_cycles", out_valid, 1);
    send(32'h0000_0800, 3'd2, 1, 25'h0000001, 1'b0);
    send(32'h0000_0801, 3'd2, 1, 25'h0000001, 1'b1);
    send(32'hFFFF_FFFE, 3'd4, 1, 25'h1FFFFE0, 1'b0);
    send(32'h1234_5001, 3'd3, 1, 25'h02468A0, 1'b1);
    send(32'd2048,      3'd1, 1, 25'h1000000, 1'b1);
    send($urandom,      3'd7, 1, 25'h0000000, 1'b1);
    drain();

    // Backpressure: capacity of two beats, then release
    out_ready = 1'b0;
    send(legal_imm(3'd0), 3'd0, 0, '0, 1'b0);
    send(legal_imm(3'd4), 3'd4, 0, '0, 1'b0);
    in_imm   = 32'h0000_0010;
    in_src   = 3'd1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h0000_0010, 3'd1, 0, '0, 1'b0);
    send(legal_imm(3'd2), 3'd2, 0, '0, 1'b0);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(legal_imm(3'd3), 3'd3, 0, '0, 1'b0);
    send(legal_imm(3'd1), 3'd1, 0, '0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_err_count", err_count, 0);
    sb_q.delete();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_no_stale", out_valid, 0);

    // Random sweep with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        src = 3'($urandom_range(0, 7));
        imm = $urandom;
      end else begin
        src = 3'($urandom_range(0, 4));
        imm = legal_imm(src);
      end
      send(imm, src, 0, '0, 1'b0);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

`ifdef IMM_ENCODER_ERR_CNT_EN
    for (int i = 0; i < (1 << ERR_CNT_W) + 3; i++) begin
      send($urandom, 3'd7, 1, 25'h0, 1'b1);
    end
    drain();
    @(posedge clk);
    #1;
    chk("err_count_sat", err_count, {ERR_CNT_W{1'b1}});
`else
    chk("err_count_tied", err_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Inverse of the core's immediate extender. Takes a 32-bit immediate value and an ImmSrc type code, and produces the scattered immediate bits of instr[31:7] as a 25-bit field. Non-immediate positions (rd, rs1, rs2, funct3) are zero, so the test/program-generation infrastructure ORs register fields and opcode on top. The block is a 2-stage valid/ready pipeline with a range checker, and it sits between the instruction-generator front end and the instruction-memory loader.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_imm  in  32  immediate value (two's complement)
- in_src  in  3  type: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_enc  out  25  encoded bits; out_enc[k] corresponds to instr[k+7]
- out_err  out  1  range violation or illegal in_src for this beat
- err_count  out  ERR_CNT_W  number of beats accepted with out_err=1 (see Optional Feature)

Behaviour:
- Reset values: in_ready=1 (after the reset cycle), out_valid=0, out_enc=0, out_err=0, err_count=0. Both pipeline stages are emptied.
- Handshake:
  - Input transfer on in_valid&in_ready.
  - Output transfer on out_valid&out_ready.
  - out_enc and out_err stay stable while out_valid=1 and out_ready=0.
  - out_valid stays high until the beat transfers.
- Pipeline:
  - S1 registers the input.
  - S2 registers the encoding and the error flag, which are computed combinationally from S1.
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 beat/cycle with no bubbles while out_ready=1.
  - S2 advance = !out_valid | out_ready; S1 advance = !s1_valid | S2 advance.
  - in_ready = S1 advance. in_ready must not depend combinationally on in_valid.
  - Full stall: both stages hold, in_ready=0, and capacity is 2 beats.
- Encoding (instr bit positions; all unlisted bits are 0):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range check (out_err=1 on violation; the truncated encoding is still emitted):
  - I/S: in_imm must be in [-2048, 2047].
  - B: in_imm must be in [-4096, 4095] and imm[0]=0.
  - U: imm[11:0] must be 0.
  - J: in_imm must be in [-2^20, 2^20-1] and imm[0]=0.
- Illegal in_src: out_enc=0 and out_err=1.
- Round-trip property: for every legal, in-range beat, extending out_enc with the same type code reproduces in_imm exactly.
- Reset asserted mid-operation discards in-flight beats with no output transfer. Reset has priority over all handshakes.

Optional Feature:
- Macro: IMM_ENCODER_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each output transfer with out_err=1.
  - It saturates at all-ones and does not wrap.
  - It clears only on reset.
- Undefined: err_count is tied to 0 and no counter flops are synthesized.

Test Plan:
- I-type, in_imm=0xFFFFFFFF (-1), out_ready=1 -> out_valid exactly 2 cycles after transfer; out_enc=0x1FFE000, out_err=0.
- B-type, in_imm=0x00000800 -> out_enc=0x0000001, out_err=0. Then B-type in_imm=0x00000801 -> out_err=1.
- J-type, in_imm=0xFFFFFFFE -> out_enc=0x1FFFFE0, out_err=0. U-type, in_imm=0x12345001 -> out_enc=0x02468A0, out_err=1. S-type, in_imm=2048 -> out_err=1.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepted; out_enc is stable. Release out_ready -> all 4 beats emerge in order with no loss or duplication.
- Illegal in_src=3'b111 -> out_enc=0, out_err=1. With the macro defined, err_count=1 after transfer; 2^ERR_CNT_W+3 error beats leave err_count at all-ones.
- Reset asserted with 2 beats in flight -> next cycle out_valid=0 and in_ready=1; no stale beat appears afterwards. Random legal sweep -> extender(out_enc) equals in_imm for all types.
